// File: rtl/if_stream_tagger.sv
// Tags a raw IFmap word stream with start-of-row / end-of-row bits and writes it
// into the IF buffer through a one-entry output register with backpressure.
module if_stream_tagger #(
  parameter int IF_SCRATCH_WIDTH = 16,
  parameter int LEN_W            = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LEN_W-1:0]            row_len,
  input  logic [LEN_W-1:0]            num_rows,
  input  logic                        src_valid,
  input  logic [IF_SCRATCH_WIDTH-1:0] src_data,
  output logic                        src_ready,
  output logic                        IF_wen,
  output logic [IF_SCRATCH_WIDTH+1:0] IF_din,
  input  logic                        IF_full,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

  state_t                        state_r;
  state_t                        state_nxt;
  logic [LEN_W-1:0]              len_r;
  logic [LEN_W-1:0]              rows_r;
  logic [LEN_W-1:0]              col_r;
  logic [LEN_W-1:0]              row_r;
  logic                          out_valid_r;
  logic [IF_SCRATCH_WIDTH+1:0]   din_r;
  logic                          empty_done_r;

  logic accept;
  logic retire;
  logic frame_ok;
  logic launch;
  logic first_col;
  logic last_col;
  logic last_word;

  assign frame_ok  = (row_len != LEN_ZERO) && (num_rows != LEN_ZERO);
  assign launch    = (state_r == IDLE) && start && frame_ok;
  assign src_ready = (state_r == RUN) && (!out_valid_r || !IF_full);
  assign accept    = src_valid && src_ready;
  assign retire    = out_valid_r && !IF_full;
  assign first_col = (col_r == LEN_ZERO);
  assign last_col  = (col_r == (len_r - LEN_ONE));
  assign last_word = last_col && (row_r == (rows_r - LEN_ONE));

  assign IF_wen = out_valid_r;
  assign IF_din = din_r;
  assign busy   = (state_r != IDLE);
  // Frame completion is signalled as the last word actually leaves, not when it is accepted.
  assign done   = empty_done_r || ((state_r == FLUSH) && retire);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (launch) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (accept && last_word) begin
          state_nxt = FLUSH;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        if (retire) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = FLUSH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame geometry capture and column/row position counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r  <= LEN_ZERO;
      rows_r <= LEN_ZERO;
      col_r  <= LEN_ZERO;
      row_r  <= LEN_ZERO;
    end else if (launch) begin
      len_r  <= row_len;
      rows_r <= num_rows;
      col_r  <= LEN_ZERO;
      row_r  <= LEN_ZERO;
    end else if (accept) begin
      if (last_col) begin
        col_r <= LEN_ZERO;
        row_r <= row_r + LEN_ONE;
      end else begin
        col_r <= col_r + LEN_ONE;
      end
    end
  end

  // One-entry output register; a new word may be loaded on the same cycle the old one retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      din_r       <= '0;
    end else if (accept) begin
      out_valid_r <= 1'b1;
      din_r       <= {first_col, last_col, src_data};
    end else if (retire) begin
      out_valid_r <= 1'b0;
    end
  end

  // Empty frame: no data moves, completion is reported on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      empty_done_r <= 1'b0;
    end else begin
      empty_done_r <= (state_r == IDLE) && start && !frame_ok;
    end
  end

endmodule

// File: tb/tb_if_stream_tagger.sv
// Directed bench for if_stream_tagger: expected tagged words are queued as the
// source hands them over and a negedge monitor checks each IF buffer write.
module tb_if_stream_tagger;

  localparam int W = 16;
  localparam int L = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [L-1:0]   row_len = '0;
  logic [L-1:0]   num_rows = '0;
  logic           src_valid = 1'b0;
  logic [W-1:0]   src_data = '0;
  logic           src_ready;
  logic           IF_wen;
  logic [W+1:0]   IF_din;
  logic           IF_full = 1'b0;
  logic           busy;
  logic           done;

  if_stream_tagger #(.IF_SCRATCH_WIDTH(W), .LEN_W(L)) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .IF_wen(IF_wen), .IF_din(IF_din), .IF_full(IF_full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W+1:0] din;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  int   n_done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted write must match the oldest queued word.
  always @(negedge clk) begin
    if (rst) begin
      if (done) n_done++;
      if (IF_wen && !IF_full) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("if_din", 32'(IF_din), 32'(mon_e.din));
          check("done_on_write", 32'(done), 32'(mon_e.last));
        end
      end
    end
  end

  task automatic do_start(input int len, input int rows);
    @(posedge clk); #1;
    start = 1'b1; row_len = L'(len); num_rows = L'(rows);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer n_send words; the expected tag is pushed when the handshake is seen.
  task automatic send_words(input int len, input int rows, input int n_send, input int base);
    int   t;
    int   col;
    exp_t e;
    for (int i = 0; i < n_send; i++) begin
      col = i % len;
      src_valid = 1'b1;
      src_data  = W'(base + i);
      t = 0;
      @(negedge clk);
      while (!src_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        check("src_ready_timeout", 32'd0, 32'd1);
        src_valid = 1'b0;
        return;
      end
      e.din  = {(col == 0), (col == len - 1), W'(base + i)};
      e.last = (i == len * rows - 1);
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("busy_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input int len, input int rows, input int base);
    int w0;
    int d0;
    w0 = n_writes;
    d0 = n_done;
    do_start(len, rows);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_words(len, rows, len * rows, base);
    wait_drain();
    check("write_count", 32'(n_writes - w0), 32'(len * rows));
    check("done_count", 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;
    int t;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", 32'(IF_wen), 32'd0);
    check("rst_din", 32'(IF_din), 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 4x2 frame, words 1..8: tags 10,00,00,01,10,00,00,01
    run_frame(4, 2, 1);

    // Single-word rows: every word tagged 11
    run_frame(1, 3, 16'h0100);

    // Backpressure: IF_full held for 5 cycles mid-frame
    w0 = n_writes;
    d0 = n_done;
    do_start(4, 3);
    fork
      send_words(4, 3, 12, 16'h0200);
      begin
        t = 0;
        while (n_writes < w0 + 3 && t < 200) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk); #1;
        IF_full = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("stall_wen", 32'(IF_wen), 32'd1);
          check("stall_ready", 32'(src_ready), 32'd0);
          if (exp_q.size() != 0) check("stall_din", 32'(IF_din), 32'(exp_q[0].din));
          else check("stall_queue", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        IF_full = 1'b0;
      end
    join
    wait_drain();
    check("stall_write_count", 32'(n_writes - w0), 32'd12);
    check("stall_done_count", 32'(n_done - d0), 32'd1);

    // Empty frame: done next cycle, no writes, never busy
    w0 = n_writes;
    do_start(4, 0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("zero_done_low", 32'(done), 32'd0);
      check("zero_busy_low", 32'(busy), 32'd0);
    end
    check("zero_writes", 32'(n_writes - w0), 32'd0);

    // Reset after 3 of 8 words
    do_start(4, 2);
    send_words(4, 2, 3, 16'h0400);
    rst = 1'b0;
    #1;
    check("mid_rst_wen", 32'(IF_wen), 32'd0);
    check("mid_rst_din", 32'(IF_din), 32'd0);
    check("mid_rst_ready", 32'(src_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    w0 = n_writes;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_wen", 32'(n_writes - w0), 32'd0);
    run_frame(4, 2, 16'h0500);

    // Start re-pulsed with other geometry during RUN must be ignored
    w0 = n_writes;
    d0 = n_done;
    fork
      begin
        do_start(3, 2);
        send_words(3, 2, 6, 16'h0600);
      end
      begin
        t = 0;
        while (n_writes < w0 + 2 && t < 200) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk); #1;
        start = 1'b1; row_len = 8'd1; num_rows = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_drain();
    check("repulse_write_count", 32'(n_writes - w0), 32'd6);
    check("repulse_done_count", 32'(n_done - d0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stream_tagger.md
IF_STREAM_TAGGER -- requirements
Module: if_stream_tagger

Interface
REQ-001 SHALL have parameter IF_SCRATCH_WIDTH, default 16, meaning the width of the raw IFmap data word.
REQ-002 SHALL have parameter LEN_W, default 8, meaning the width of the row-length and row-count fields.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle pulse that begins a frame.
REQ-006 SHALL have port row_len, input, LEN_W bits, words per row; sampled on accepted start.
REQ-007 SHALL have port num_rows, input, LEN_W bits, rows per frame; sampled on accepted start.
REQ-008 SHALL have port src_valid, input, 1 bit, meaning src_data is valid.
REQ-009 SHALL have port src_data, input, IF_SCRATCH_WIDTH bits, the raw IFmap word.
REQ-010 SHALL have port src_ready, output, 1 bit, meaning the tagger accepts src_data this cycle.
REQ-011 SHALL have port IF_wen, output, 1 bit, the write enable to the design_top IF buffer.
REQ-012 SHALL have port IF_din, output, IF_SCRATCH_WIDTH+2 bits, carrying the tagged word.
REQ-013 SHALL have port IF_full, input, 1 bit, the IF buffer full flag.
REQ-014 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-015 SHALL have port done, output, 1 bit, a one-cycle pulse when the last word of a frame is written.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-017 SHALL go IDLE->RUN on start when row_len!=0 and num_rows!=0, clearing the col and row counters.
REQ-018 SHALL ignore start while in RUN or FLUSH.
REQ-019 SHALL, on start with row_len==0 or num_rows==0, stay IDLE and pulse done the next cycle, with no IF_wen asserted.
REQ-020 SHALL accept a source word only when src_valid&&src_ready.
REQ-021 SHALL define src_ready = (state==RUN) && (!out_valid || !IF_full).
REQ-022 SHALL load each accepted word into a one-entry output register (out_valid, IF_din), so that IF_din appears on the cycle after acceptance.
REQ-023 SHALL format IF_din as {sor, eor, data}, where bit IF_SCRATCH_WIDTH+1 = start-of-row (col==0) and bit IF_SCRATCH_WIDTH = end-of-row (col==row_len-1).
REQ-024 SHALL set both tag bits when row_len==1.
REQ-025 SHALL drive IF_wen = out_valid.
REQ-026 SHALL retire the output word only on a cycle with IF_wen && !IF_full, and SHALL hold IF_din stable until then.
REQ-027 SHALL allow an accept and a retire in the same cycle, giving one word per cycle throughput when IF_full is low.
REQ-028 SHALL step col on each accept, wrapping col from row_len-1 to 0 and incrementing row on the wrap.
REQ-029 SHALL go RUN->FLUSH when the final word (row==num_rows-1, col==row_len-1) is accepted, with src_ready low from the next cycle.
REQ-030 SHALL go FLUSH->IDLE on the cycle the final word retires, and SHALL pulse done on that same cycle.
REQ-031 SHALL drive busy = (state!=IDLE).
REQ-032 SHALL hold the row_len and num_rows captures constant for the whole frame, ignoring input changes.
REQ-033 SHALL count with LEN_W-bit unsigned counters that never overflow, because row_len and num_rows are at most 2^LEN_W-1.

Reset
REQ-034 SHALL, on rst low at any time (including mid-frame), immediately force: state=IDLE, out_valid=0, IF_wen=0, IF_din=0, src_ready=0, busy=0, done=0, counters=0.
REQ-035 SHALL discard any partially sent frame on reset, with no further IF_wen until a new start.
REQ-036 SHALL respond to the first start after rst returns high.

Verification
REQ-037 SHALL be verified with: row_len=4, num_rows=2, words 1..8, IF_full=0 -> eight IF_wen cycles; IF_din tags 10,00,00,01,10,00,00,01; done on 8th write.
REQ-038 SHALL be verified with: row_len=1, num_rows=3 -> every IF_din has tag 11; three writes; done once.
REQ-039 SHALL be verified with: IF_full high for 5 cycles mid-frame -> IF_din stable, src_ready low, no word lost or duplicated.
REQ-040 SHALL be verified with: start with num_rows=0 -> done pulses the next cycle, IF_wen never high, busy stays 0.
REQ-041 SHALL be verified with: rst low after 3 of 8 words -> all outputs 0 immediately; a new start then gives a clean frame beginning with tag 10.
REQ-042 SHALL be verified with: start re-pulsed during RUN -> ignored; counters and frame unaffected.
